// File: rtl/operand_stage_pkg.sv
// Shared types and decode helpers for the operand stage.
//   op_class_t : instruction class used to steer the operand FSM
//   state_t    : operand FSM states
//   op_class() : classifies a 6502-style opcode (aaabbbcc fields)
package operand_stage_pkg;

  typedef enum logic [2:0] {
    CLS_IMPLIED,
    CLS_IMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_RMW
  } op_class_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_RD_WAIT,
    ST_WR_WAIT,
    ST_ISSUE,
    ST_RMW_WAIT,
    ST_RETIRE
  } state_t;

  // cc field (opcode[1:0]) groups
  localparam logic [1:0] OPP_CC_00 = 2'b00;
  localparam logic [1:0] OPP_CC_01 = 2'b01;
  localparam logic [1:0] OPP_CC_10 = 2'b10;
  localparam logic [1:0] OPP_CC_11 = 2'b11;

  // bbb field (opcode[4:2]) addressing-mode codes
  localparam logic [2:0] AM3_000  = 3'b000;
  localparam logic [2:0] AM3_IMM  = 3'b010;
  localparam logic [2:0] AM3_IMPL = 3'b110;

  // aaa field values that matter for classification
  localparam logic [2:0] OPP_AAA_ST  = 3'b100;
  localparam logic [2:0] OPP_AAA_LDX = 3'b101;

  localparam logic [7:0] OPP_BRK = 8'h00;
  localparam logic [7:0] OPP_RTI = 8'h40;
  localparam logic [7:0] OPP_RTS = 8'h60;

  // Priority order matters: IMM before IMPLIED before STORE, so that
  // TXA/TYA/TXS/DEY (aaa=100) fall into IMPLIED rather than STORE.
  function automatic op_class_t op_class(input logic [7:0] op);
    logic [2:0] aaa;
    logic [2:0] bbb;
    logic [1:0] cc;
    aaa = op[7:5];
    bbb = op[4:2];
    cc  = op[1:0];
    if ((cc == OPP_CC_01 && bbb == AM3_IMM) ||
        (cc == OPP_CC_00 && bbb == AM3_000 && aaa >= OPP_AAA_LDX) ||
        (cc == OPP_CC_10 && bbb == AM3_000 && aaa == OPP_AAA_LDX) ||
        (op[4:0] == 5'b10000))
      return CLS_IMM;
    if (((bbb == AM3_IMM || bbb == AM3_IMPL) && (cc == OPP_CC_00 || cc == OPP_CC_10)) ||
        op == OPP_BRK || op == OPP_RTI || op == OPP_RTS)
      return CLS_IMPLIED;
    if (aaa == OPP_AAA_ST && cc != OPP_CC_11)
      return CLS_STORE;
    if (cc == OPP_CC_10 && (aaa <= 3'b011 || aaa >= 3'b110) && bbb[0])
      return CLS_RMW;
    return CLS_LOAD;
  endfunction

endpackage

// File: rtl/operand_stage_if.sv
// Memory bus and ALU handshake bundle for the operand stage.
//   master : operand stage side (drives mem_req/we/addr/wdata, alu_valid/opcode/operand)
//   slave  : memory + ALU side (drives mem_rdata/ack, alu_ready/result/result_valid)
interface operand_stage_if #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [REG_WIDTH-1:0]  mem_wdata;
  logic [REG_WIDTH-1:0]  mem_rdata;
  logic                  mem_ack;
  logic                  alu_valid;
  logic [REG_WIDTH-1:0]  alu_opcode;
  logic [REG_WIDTH-1:0]  alu_operand;
  logic                  alu_ready;
  logic [REG_WIDTH-1:0]  alu_result;
  logic                  alu_result_valid;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, alu_valid, alu_opcode, alu_operand,
    input  mem_rdata, mem_ack, alu_ready, alu_result, alu_result_valid
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, alu_valid, alu_opcode, alu_operand,
    output mem_rdata, mem_ack, alu_ready, alu_result, alu_result_valid
  );
endinterface

// File: rtl/operand_stage_mem_req_ctrl.sv
// Memory request controller: holds one request (req/we/addr/wdata) from a
// start pulse until ack or timeout, and keeps the sticky bus_error flag.
//   clk, rst      : clock, async active-high reset
//   start*        : launch a request with the given direction/address/data
//   ack           : memory acknowledge (ignored unless req is high)
//   req/we/addr/wdata : registered request outputs, frozen while req=1
//   ack_ok        : request completes this cycle
//   timeout       : request abandoned this cycle (no ack within MEM_TIMEOUT)
//   bus_error     : sticky timeout flag
module mem_req_ctrl #(
  parameter int REG_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  start_we,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [REG_WIDTH-1:0]  start_wdata,
  input  logic                  ack,
  output logic                  req,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [REG_WIDTH-1:0]  wdata,
  output logic                  ack_ok,
  output logic                  timeout,
  output logic                  bus_error
);
  localparam logic [3:0] CNT_LAST = 4'(MEM_TIMEOUT - 1);

  logic [3:0] cnt;

  // ack takes priority over a timeout landing in the same cycle
  assign ack_ok  = req & ack;
  assign timeout = req & ~ack & (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req       <= 1'b0;
      we        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      cnt       <= '0;
      bus_error <= 1'b0;
    end else if (start) begin
      req   <= 1'b1;
      we    <= start_we;
      addr  <= start_addr;
      wdata <= start_wdata;
      cnt   <= '0;
    end else if (ack_ok) begin
      req <= 1'b0;
    end else if (timeout) begin
      req       <= 1'b0;
      bus_error <= 1'b1;
    end else if (req) begin
      cnt <= cnt + 4'd1;
    end
  end
endmodule

// File: rtl/operand_stage.sv
// Operand stage: captures opcode/address/immediate from the fetcher on a
// rising instruction_ready, fetches the memory operand or writes store data,
// presents the operand to the ALU, writes back RMW results and pulses
// instruction_done on retire.
//   phi1, reset                        : clock, async active-high reset
//   instruction_ready/_in, addr_in, imm_in : fetcher interface
//   store_data                         : A/X/Y value for stores
//   bus (master)                       : memory request + ALU handshake
//   instruction_done                   : one-cycle retire pulse
//   bus_error, overrun                 : sticky error flags
module operand_stage
  import operand_stage_pkg::*;
#(
  parameter int REG_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  phi1,
  input  logic                  reset,
  input  logic                  instruction_ready,
  input  logic [REG_WIDTH-1:0]  instruction_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [REG_WIDTH-1:0]  imm_in,
  input  logic [REG_WIDTH-1:0]  store_data,
  operand_stage_if.master       bus,
  output logic                  instruction_done,
  output logic                  bus_error,
  output logic                  overrun
);
  state_t                state, next_state;
  op_class_t             cls;
  logic                  ready_q;
  logic                  rise;
  logic [REG_WIDTH-1:0]  opcode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [REG_WIDTH-1:0]  imm_q;
  logic [REG_WIDTH-1:0]  operand_q;
  logic                  mem_start;
  logic                  start_we;
  logic [REG_WIDTH-1:0]  start_wdata;
  logic                  ack_ok;
  logic                  timeout;

  assign rise = instruction_ready & ~ready_q;
  assign cls  = op_class(opcode_q[7:0]);

  assign bus.alu_valid   = (state == ST_ISSUE);
  assign bus.alu_opcode  = opcode_q;
  assign bus.alu_operand = operand_q;
  assign instruction_done = (state == ST_RETIRE);

  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    mem_start   = 1'b0;
    start_we    = 1'b0;
    start_wdata = store_data;
    unique case (state)
      ST_IDLE: if (rise) next_state = ST_DISPATCH;
      ST_DISPATCH: begin
        unique case (cls)
          CLS_IMPLIED, CLS_IMM: next_state = ST_ISSUE;
          CLS_LOAD, CLS_RMW: begin
            next_state = ST_RD_WAIT;
            mem_start  = 1'b1;
          end
          CLS_STORE: begin
            next_state = ST_WR_WAIT;
            mem_start  = 1'b1;
            start_we   = 1'b1;
          end
          default: next_state = ST_ISSUE;
        endcase
      end
      ST_RD_WAIT: begin
        if (ack_ok)       next_state = ST_ISSUE;
        else if (timeout) next_state = ST_RETIRE;
      end
      ST_ISSUE: if (bus.alu_ready) next_state = (cls == CLS_RMW) ? ST_RMW_WAIT : ST_RETIRE;
      ST_RMW_WAIT: begin
        if (bus.alu_result_valid) begin
          next_state  = ST_WR_WAIT;
          mem_start   = 1'b1;
          start_we    = 1'b1;
          start_wdata = bus.alu_result;
        end
      end
      ST_WR_WAIT: if (ack_ok || timeout) next_state = ST_RETIRE;
      ST_RETIRE:  next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      ready_q   <= 1'b0;
      overrun   <= 1'b0;
      opcode_q  <= '0;
      addr_q    <= '0;
      imm_q     <= '0;
      operand_q <= '0;
    end else begin
      ready_q <= instruction_ready;
      if (rise && state != ST_IDLE) overrun <= 1'b1;
      if (rise && state == ST_IDLE) begin
        opcode_q <= instruction_in;
        addr_q   <= addr_in;
        imm_q    <= imm_in;
      end
      if (state == ST_DISPATCH && (cls == CLS_IMM || cls == CLS_IMPLIED))
        operand_q <= (cls == CLS_IMPLIED) ? '0 : imm_q;
      if (state == ST_RD_WAIT && ack_ok) operand_q <= bus.mem_rdata;
    end
  end

  mem_req_ctrl #(
    .REG_WIDTH  (REG_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_req_ctrl (
    .clk        (phi1),
    .rst        (reset),
    .start      (mem_start),
    .start_we   (start_we),
    .start_addr (addr_q),
    .start_wdata(start_wdata),
    .ack        (bus.mem_ack),
    .req        (bus.mem_req),
    .we         (bus.mem_we),
    .addr       (bus.mem_addr),
    .wdata      (bus.mem_wdata),
    .ack_ok     (ack_ok),
    .timeout    (timeout),
    .bus_error  (bus_error)
  );
endmodule

// File: tb/tb_operand_stage.sv
// Directed self-checking bench for operand_stage.
module tb_operand_stage;
  logic        phi1;
  logic        reset;
  logic        instruction_ready;
  logic [7:0]  instruction_in;
  logic [15:0] addr_in;
  logic [7:0]  imm_in;
  logic [7:0]  store_data;
  logic        instruction_done;
  logic        bus_error;
  logic        overrun;

  int unsigned total;
  int unsigned bad;

  operand_stage_if #(.REG_WIDTH(8), .ADDR_WIDTH(16)) bus ();

  operand_stage #(.REG_WIDTH(8), .ADDR_WIDTH(16), .MEM_TIMEOUT(15)) dut (
    .phi1             (phi1),
    .reset            (reset),
    .instruction_ready(instruction_ready),
    .instruction_in   (instruction_in),
    .addr_in          (addr_in),
    .imm_in           (imm_in),
    .store_data       (store_data),
    .bus              (bus.master),
    .instruction_done (instruction_done),
    .bus_error        (bus_error),
    .overrun          (overrun)
  );

  initial phi1 = 1'b0;
  always #5 phi1 = ~phi1;

  task automatic tick();
    @(posedge phi1);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [7:0] op, input logic [15:0] a, input logic [7:0] imm);
    instruction_in    = op;
    addr_in           = a;
    imm_in            = imm;
    instruction_ready = 1'b1;
    tick();
    instruction_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    instruction_ready = 1'b0;
    instruction_in = '0;
    addr_in = '0;
    imm_in = '0;
    store_data = '0;
    bus.mem_rdata = '0;
    bus.mem_ack = 1'b0;
    bus.alu_ready = 1'b0;
    bus.alu_result = '0;
    bus.alu_result_valid = 1'b0;
    repeat (2) tick();

    // reset state
    chk1("rst_mem_req", bus.mem_req, 1'b0);
    chk1("rst_mem_we", bus.mem_we, 1'b0);
    chk16("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk8("rst_mem_wdata", bus.mem_wdata, 8'h00);
    chk1("rst_alu_valid", bus.alu_valid, 1'b0);
    chk8("rst_alu_opcode", bus.alu_opcode, 8'h00);
    chk8("rst_alu_operand", bus.alu_operand, 8'h00);
    chk1("rst_done", instruction_done, 1'b0);
    chk1("rst_bus_error", bus_error, 1'b0);
    chk1("rst_overrun", overrun, 1'b0);
    reset = 1'b0;
    tick();

    // LDA #$42 : stray mem_ack while idle must be ignored
    bus.mem_ack = 1'b1;
    bus.alu_ready = 1'b1;
    launch(8'hA9, 16'h0000, 8'h42);
    chk1("imm_valid_e0", bus.alu_valid, 1'b0);
    chk1("imm_req_e0", bus.mem_req, 1'b0);
    tick();
    chk1("imm_valid_e1", bus.alu_valid, 1'b1);
    chk8("imm_operand", bus.alu_operand, 8'h42);
    chk8("imm_opcode", bus.alu_opcode, 8'hA9);
    chk1("imm_req_e1", bus.mem_req, 1'b0);
    chk1("imm_done_e1", instruction_done, 1'b0);
    tick();
    chk1("imm_done_e2", instruction_done, 1'b1);
    chk1("imm_valid_e2", bus.alu_valid, 1'b0);
    tick();
    chk1("imm_done_e3", instruction_done, 1'b0);
    bus.mem_ack = 1'b0;

    // LDA $0010, ack two cycles late
    launch(8'hAD, 16'h0010, 8'h00);
    tick();
    chk1("lda_req_e1", bus.mem_req, 1'b1);
    chk16("lda_addr", bus.mem_addr, 16'h0010);
    chk1("lda_we", bus.mem_we, 1'b0);
    tick();
    chk1("lda_req_e2", bus.mem_req, 1'b1);
    tick();
    chk1("lda_req_e3", bus.mem_req, 1'b1);
    chk1("lda_valid_e3", bus.alu_valid, 1'b0);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 8'h5A;
    tick();
    bus.mem_ack = 1'b0;
    chk1("lda_req_drop", bus.mem_req, 1'b0);
    chk1("lda_valid_e4", bus.alu_valid, 1'b1);
    chk8("lda_operand", bus.alu_operand, 8'h5A);
    chk1("lda_done_e4", instruction_done, 1'b0);
    tick();
    chk1("lda_done_e5", instruction_done, 1'b1);
    tick();
    chk1("lda_done_e6", instruction_done, 1'b0);

    // STA $0200, store_data=77, zero-wait ack
    store_data = 8'h77;
    bus.mem_ack = 1'b1;
    launch(8'h8D, 16'h0200, 8'h00);
    chk1("sta_valid_e0", bus.alu_valid, 1'b0);
    tick();
    chk1("sta_req", bus.mem_req, 1'b1);
    chk1("sta_we", bus.mem_we, 1'b1);
    chk16("sta_addr", bus.mem_addr, 16'h0200);
    chk8("sta_wdata", bus.mem_wdata, 8'h77);
    chk1("sta_valid_e1", bus.alu_valid, 1'b0);
    tick();
    chk1("sta_req_drop", bus.mem_req, 1'b0);
    chk1("sta_done", instruction_done, 1'b1);
    chk1("sta_valid_e2", bus.alu_valid, 1'b0);
    tick();
    chk1("sta_done_end", instruction_done, 1'b0);
    chk1("sta_single_req", bus.mem_req, 1'b0);

    // ASL $0030, rdata 81, alu_result 02
    bus.mem_rdata = 8'h81;
    bus.alu_result = 8'h02;
    bus.alu_result_valid = 1'b1;
    launch(8'h06, 16'h0030, 8'h00);
    tick();
    chk1("asl_rd_req", bus.mem_req, 1'b1);
    chk1("asl_rd_we", bus.mem_we, 1'b0);
    chk16("asl_rd_addr", bus.mem_addr, 16'h0030);
    tick();
    chk1("asl_req_e2", bus.mem_req, 1'b0);
    chk1("asl_valid", bus.alu_valid, 1'b1);
    chk8("asl_operand", bus.alu_operand, 8'h81);
    chk8("asl_opcode", bus.alu_opcode, 8'h06);
    tick();
    chk1("asl_valid_drop", bus.alu_valid, 1'b0);
    chk1("asl_req_e3", bus.mem_req, 1'b0);
    chk1("asl_done_e3", instruction_done, 1'b0);
    tick();
    chk1("asl_wr_req", bus.mem_req, 1'b1);
    chk1("asl_wr_we", bus.mem_we, 1'b1);
    chk16("asl_wr_addr", bus.mem_addr, 16'h0030);
    chk8("asl_wr_wdata", bus.mem_wdata, 8'h02);
    chk1("asl_done_e4", instruction_done, 1'b0);
    tick();
    chk1("asl_done_e5", instruction_done, 1'b1);
    chk1("asl_wr_drop", bus.mem_req, 1'b0);
    tick();
    chk1("asl_done_e6", instruction_done, 1'b0);
    bus.alu_result_valid = 1'b0;
    bus.mem_ack = 1'b0;

    // LOAD with no ack: timeout after 15 unacked cycles
    launch(8'hAD, 16'h1234, 8'h00);
    tick();
    chk1("tmo_req_e1", bus.mem_req, 1'b1);
    repeat (14) tick();
    chk1("tmo_req_e15", bus.mem_req, 1'b1);
    chk1("tmo_err_e15", bus_error, 1'b0);
    chk1("tmo_done_e15", instruction_done, 1'b0);
    tick();
    chk1("tmo_err_e16", bus_error, 1'b1);
    chk1("tmo_req_e16", bus.mem_req, 1'b0);
    chk1("tmo_done_e16", instruction_done, 1'b1);
    chk1("tmo_valid_e16", bus.alu_valid, 1'b0);
    tick();
    chk1("tmo_done_e17", instruction_done, 1'b0);
    chk1("tmo_err_sticky", bus_error, 1'b1);
    reset = 1'b1;
    #1;
    chk1("tmo_err_clr", bus_error, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    // ack arrives on the very cycle the timeout would fire: ack wins
    launch(8'hAD, 16'h4321, 8'h00);
    tick();
    repeat (14) tick();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 8'hC3;
    tick();
    bus.mem_ack = 1'b0;
    chk1("race_err", bus_error, 1'b0);
    chk1("race_req", bus.mem_req, 1'b0);
    chk1("race_valid", bus.alu_valid, 1'b1);
    chk8("race_operand", bus.alu_operand, 8'hC3);
    tick();
    chk1("race_done", instruction_done, 1'b1);
    tick();

    // reset while waiting on a write: everything clears, no retire
    store_data = 8'h99;
    launch(8'h8D, 16'hABCD, 8'h00);
    tick();
    chk1("rwr_req", bus.mem_req, 1'b1);
    chk1("rwr_we", bus.mem_we, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk1("rwr_req_clr", bus.mem_req, 1'b0);
    chk1("rwr_we_clr", bus.mem_we, 1'b0);
    chk16("rwr_addr_clr", bus.mem_addr, 16'h0000);
    chk8("rwr_wdata_clr", bus.mem_wdata, 8'h00);
    chk8("rwr_opcode_clr", bus.alu_opcode, 8'h00);
    chk8("rwr_operand_clr", bus.alu_operand, 8'h00);
    chk1("rwr_done_clr", instruction_done, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk1("rwr_no_done", instruction_done, 1'b0);
    chk1("rwr_no_req", bus.mem_req, 1'b0);
    launch(8'hA9, 16'h0000, 8'h11);
    tick();
    chk1("rwr_new_valid", bus.alu_valid, 1'b1);
    chk8("rwr_new_operand", bus.alu_operand, 8'h11);
    tick();
    chk1("rwr_new_done", instruction_done, 1'b1);
    tick();

    // INX (E8) is implied: operand forced to 0 despite imm_in
    launch(8'hE8, 16'h0000, 8'h55);
    tick();
    chk1("inx_valid", bus.alu_valid, 1'b1);
    chk8("inx_operand", bus.alu_operand, 8'h00);
    chk8("inx_opcode", bus.alu_opcode, 8'hE8);
    chk1("inx_req", bus.mem_req, 1'b0);
    tick();
    chk1("inx_done", instruction_done, 1'b1);
    tick();

    // second edge while stalled in ISSUE: ignored, overrun set, ALU inputs held
    bus.alu_ready = 1'b0;
    launch(8'hA9, 16'h0000, 8'h66);
    tick();
    chk1("ovr_valid_e1", bus.alu_valid, 1'b1);
    chk1("ovr_flag_e1", overrun, 1'b0);
    instruction_in = 8'hAD;
    imm_in = 8'h00;
    instruction_ready = 1'b1;
    tick();
    instruction_ready = 1'b0;
    chk1("ovr_flag", overrun, 1'b1);
    chk1("ovr_valid_held", bus.alu_valid, 1'b1);
    chk8("ovr_opcode_held", bus.alu_opcode, 8'hA9);
    chk8("ovr_operand_held", bus.alu_operand, 8'h66);
    bus.alu_ready = 1'b1;
    tick();
    chk1("ovr_done", instruction_done, 1'b1);
    chk1("ovr_valid_drop", bus.alu_valid, 1'b0);
    tick();
    chk1("ovr_done_end", instruction_done, 1'b0);
    chk1("ovr_no_req", bus.mem_req, 1'b0);
    chk1("ovr_sticky", overrun, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
